// File: rtl/zero_unpadding_pkg.sv
// Shared CNN definitions: frame FSM encoding, default word width and sizing helper.
package zero_unpadding_pkg;

    localparam int CNN_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } cnn_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster position counter for the padded frame plus decode of the interior window,
// the last padded pixel and the last interior pixel.
module pad_pos_counter
    import zero_unpadding_pkg::*;
#(
    parameter int IMG_W = 34,
    parameter int IMG_H = 34,
    parameter int PAD   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic advance_i,
    output logic interior_o,
    output logic frame_end_o,
    output logic last_interior_o
);

    localparam int CW = cnt_width(IMG_W);
    localparam int RW = cnt_width(IMG_H);

    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_LO  = CW'(PAD);
    localparam logic [CW-1:0] COL_HI  = CW'(IMG_W - PAD - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_LO  = RW'(PAD);
    localparam logic [RW-1:0] ROW_HI  = RW'(IMG_H - PAD - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_wrap;

    assign col_wrap = (col_q == COL_MAX);

    // NOTE: next-state defaults are assigned first so no path leaves col_d/row_d unassigned (no latch).
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign interior_o      = (row_q >= ROW_LO) && (row_q <= ROW_HI) &&
                             (col_q >= COL_LO) && (col_q <= COL_HI);
    assign frame_end_o     = (row_q == ROW_MAX) && col_wrap;
    assign last_interior_o = (row_q == ROW_HI) && (col_q == COL_HI);

endmodule

// File: rtl/zero_unpadding.sv
// Strips a PAD-pixel border from a raster-order padded frame, emitting interior pixels
// through a single ready/valid output register. Define ZERO_UNPADDING_CHECK_EN for pad_err.
module zero_unpadding
    import zero_unpadding_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int IMG_W      = 34,
    parameter int IMG_H      = 34,
    parameter int PAD        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  busy
`ifdef ZERO_UNPADDING_CHECK_EN
    ,
    output logic                  pad_err
`endif
);

    cnn_state_e            state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  accept, start_frame;
    logic                  interior, frame_end, last_interior;

    // A new word may enter only while the output register is empty or being emptied.
    assign in_ready    = (state_q == ST_ACTIVE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign start_frame = (state_q == ST_IDLE) && start;

    pad_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PAD   (PAD)
    ) u_pos (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (start_frame),
        .advance_i       (accept),
        .interior_o      (interior),
        .frame_end_o     (frame_end),
        .last_interior_o (last_interior)
    );

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_ACTIVE;
            ST_ACTIVE: if (accept && frame_end) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // A fresh interior word overrides the drain, keeping out_valid high across a take.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept && interior) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = last_interior;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef ZERO_UNPADDING_CHECK_EN
    logic pad_err_q;
    logic border_nonzero;

    // Sign bit is ignored so that both +0.0 and -0.0 count as valid padding.
    assign border_nonzero = accept && !interior && (in_data[DATA_WIDTH-2:0] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_err_q <= 1'b0;
        end else if (start_frame) begin
            pad_err_q <= 1'b0;
        end else if (border_nonzero) begin
            pad_err_q <= 1'b1;
        end
    end

    assign pad_err = pad_err_q;
`endif

endmodule

// File: tb/tb_zero_unpadding.sv
// Self-checking bench for zero_unpadding: a 4x4/PAD=1 instance under random handshakes
// and a 2x2/PAD=0 pass-through instance, both against a raster-position reference model.
`timescale 1ns/1ps
module tb_zero_unpadding;

    localparam int AW = 4;
    localparam int AH = 4;
    localparam int AP = 1;
    localparam int AN = AW * AH;

    typedef logic [31:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic        a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic        a_out_last, a_frame_done, a_busy;
    logic [31:0] a_in_data, a_out_data;
    logic        b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic        b_out_last, b_frame_done, b_busy;
    logic [31:0] b_in_data, b_out_data;
`ifdef ZERO_UNPADDING_CHECK_EN
    logic        a_pad_err, b_pad_err;
`endif

    zero_unpadding #(.DATA_WIDTH(32), .IMG_W(AW), .IMG_H(AH), .PAD(AP)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
        .frame_done(a_frame_done), .busy(a_busy)
`ifdef ZERO_UNPADDING_CHECK_EN
        , .pad_err(a_pad_err)
`endif
    );

    zero_unpadding #(.DATA_WIDTH(32), .IMG_W(2), .IMG_H(2), .PAD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .frame_done(b_frame_done), .busy(b_busy)
`ifdef ZERO_UNPADDING_CHECK_EN
        , .pad_err(b_pad_err)
`endif
    );

    // Reference rule: pixel i of a raster frame is interior iff it lies PAD away from every edge.
    function automatic bit is_interior(input int i);
        int r = i / AW;
        int c = i % AW;
        return (r >= AP) && (r < AH - AP) && (c >= AP) && (c < AW - AP);
    endfunction

    function automatic word_q_t ramp();
        word_q_t w;
        for (int i = 0; i < AN; i++) w.push_back(32'(i));
        return w;
    endfunction

    function automatic word_q_t rand_frame();
        word_q_t w;
        for (int i = 0; i < AN; i++) w.push_back($urandom);
        return w;
    endfunction

    // Streams one frame into dut_a with random gaps/backpressure and checks every cycle.
    task automatic run_a(input word_q_t words, input int vpct, input int rpct,
                         input int restart_after, input int stall_idx,
                         input int abort_after, input string tag);
        logic [31:0] exp_q[$];
        int          idx = 0, oidx = 0, dones = 0, last_in = -1, last_out = -1, stall_left = 0;
        bit          restarted = 0, stalled = 0, prev_hold = 0, prev_int = 0, exp_pe = 0;
        logic [31:0] prev_data = '0, prev_word = '0;
        logic        prev_last = 1'b0;
        for (int i = 0; i < AN; i++) if (is_interior(i)) exp_q.push_back(words[i]);
        @(negedge clk);
        a_start = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (abort_after >= 0 && idx > abort_after) begin
                a_start = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
                return;
            end
            a_start = !restarted && restart_after >= 0 && idx == restart_after + 1;
            if (a_start) restarted = 1;
            a_in_valid = (idx < AN) && ($urandom_range(99) < vpct);
            a_in_data  = (idx < AN) ? words[idx] : $urandom;
            if (!stalled && stall_idx >= 0 && a_out_valid && oidx == stall_idx) begin
                stalled = 1; stall_left = 3;
            end
            if (stall_left > 0) begin a_out_ready = 1'b0; stall_left--; end
            else a_out_ready = ($urandom_range(99) < rpct);
            #1;
            if (cyc == 0) begin
                n_total++;
                if (a_busy !== 1'b1) $display("FAIL %s busy_after_start got=%b want=1", tag, a_busy);
                else n_pass++;
            end
            if (prev_int) begin
                n_total++;
                if (a_out_valid !== 1'b1 || a_out_data !== prev_word)
                    $display("FAIL %s latency cyc=%0d got v=%b d=%h want v=1 d=%h", tag, cyc, a_out_valid, a_out_data, prev_word);
                else n_pass++;
            end
            if (prev_hold) begin
                n_total++;
                if (a_out_valid !== 1'b1 || a_out_data !== prev_data || a_out_last !== prev_last)
                    $display("FAIL %s hold cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", tag, cyc, a_out_valid, a_out_data, a_out_last, prev_data, prev_last);
                else n_pass++;
            end
            if (a_out_valid && !a_out_ready) begin
                n_total++;
                if (a_in_ready !== 1'b0) $display("FAIL %s in_ready_blocked cyc=%0d got=%b want=0", tag, cyc, a_in_ready);
                else n_pass++;
            end
            if (idx == AN) begin
                n_total++;
                if (a_in_ready !== 1'b0) $display("FAIL %s in_ready_after_frame cyc=%0d got=%b want=0", tag, cyc, a_in_ready);
                else n_pass++;
            end
`ifdef ZERO_UNPADDING_CHECK_EN
            n_total++;
            if (a_pad_err !== exp_pe) $display("FAIL %s pad_err cyc=%0d got=%b want=%b", tag, cyc, a_pad_err, exp_pe);
            else n_pass++;
`endif
            if (a_out_valid && a_out_ready) begin
                n_total++;
                if (oidx >= exp_q.size())
                    $display("FAIL %s extra_output got=%h want=none", tag, a_out_data);
                else if (a_out_data !== exp_q[oidx] || a_out_last !== (oidx == exp_q.size() - 1))
                    $display("FAIL %s out[%0d] got d=%h l=%b want d=%h l=%b", tag, oidx, a_out_data, a_out_last, exp_q[oidx], oidx == exp_q.size() - 1);
                else n_pass++;
                oidx++; last_out = cyc;
            end
            if (a_frame_done) begin
                dones++;
                n_total++;
                if (cyc != ((last_in > last_out) ? last_in : last_out) + 1 || idx != AN || oidx != exp_q.size())
                    $display("FAIL %s frame_done_timing got cyc=%0d in=%0d out=%0d want cyc=%0d in=%0d out=%0d", tag, cyc, idx, oidx, ((last_in > last_out) ? last_in : last_out) + 1, AN, exp_q.size());
                else n_pass++;
            end
            prev_hold = a_out_valid && !a_out_ready;
            prev_data = a_out_data;
            prev_last = a_out_last;
            prev_int  = 0;
            if (a_in_valid && a_in_ready) begin
                prev_int  = is_interior(idx);
                prev_word = words[idx];
                if (!is_interior(idx) && (words[idx] & 32'h7fff_ffff) != 0) exp_pe = 1;
                idx++; last_in = cyc;
            end
            if (dones > 0) break;
        end
        n_total++;
        if (dones != 1 || oidx != exp_q.size())
            $display("FAIL %s frame_complete got done=%0d outs=%0d want done=1 outs=%0d", tag, dones, oidx, exp_q.size());
        else n_pass++;
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b0;
        #1;
        n_total++;
        if (a_busy !== 1'b0 || a_frame_done !== 1'b0)
            $display("FAIL %s idle_after_frame got busy=%b done=%b want 0 0", tag, a_busy, a_frame_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 1'b1; a_in_valid = 1'b1; a_in_data = 32'hdead_beef; a_out_ready = 1'b1;
        b_start = 1'b1; b_in_valid = 1'b1; b_in_data = 32'h1234_5678; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({a_out_valid, a_out_last, a_frame_done, a_busy, a_in_ready} !== 5'b0 || a_out_data !== 32'h0)
            $display("FAIL reset_a got v=%b l=%b fd=%b busy=%b ir=%b d=%h want all 0", a_out_valid, a_out_last, a_frame_done, a_busy, a_in_ready, a_out_data);
        else n_pass++;
        n_total++;
        if ({b_out_valid, b_out_last, b_frame_done, b_busy, b_in_ready} !== 5'b0 || b_out_data !== 32'h0)
            $display("FAIL reset_b got v=%b l=%b fd=%b busy=%b ir=%b d=%h want all 0", b_out_valid, b_out_last, b_frame_done, b_busy, b_in_ready, b_out_data);
        else n_pass++;
`ifdef ZERO_UNPADDING_CHECK_EN
        n_total++;
        if (a_pad_err !== 1'b0 || b_pad_err !== 1'b0) $display("FAIL reset_pad_err got=%b%b want=00", a_pad_err, b_pad_err);
        else n_pass++;
`endif
        @(negedge clk);
        a_start = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_total++;
        if (a_busy !== 1'b0 || a_in_ready !== 1'b0) $display("FAIL idle_no_start got busy=%b ir=%b want 0 0", a_busy, a_in_ready);
        else n_pass++;
    endtask

    task automatic test_frame_basic();
        run_a(ramp(), 100, 100, -1, -1, -1, "basic");
    endtask

    task automatic test_backpressure();
        run_a(ramp(), 100, 100, -1, 1, -1, "stall6");
    endtask

    task automatic test_restart_ignored();
        run_a(ramp(), 100, 100, 7, -1, -1, "restart");
    endtask

    task automatic test_reset_mid_frame();
        run_a(ramp(), 100, 100, -1, -1, 9, "pre_reset");
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_out_valid, a_out_last, a_busy, a_in_ready, a_frame_done} !== 5'b0 || a_out_data !== 32'h0)
            $display("FAIL async_reset got v=%b l=%b busy=%b ir=%b fd=%b d=%h want all 0", a_out_valid, a_out_last, a_busy, a_in_ready, a_frame_done, a_out_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_a(ramp(), 100, 100, -1, -1, -1, "post_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++)
            run_a(rand_frame(), 40 + $urandom_range(60), 30 + $urandom_range(70), -1, -1, -1, "random");
    endtask

    task automatic test_back_to_back();
        run_a(rand_frame(), 100, 100, -1, -1, -1, "b2b_0");
        run_a(rand_frame(), 100, 100, -1, -1, -1, "b2b_1");
    endtask

    task automatic test_pad0();
        int idx = 0, got = 0, dones = 0, last_take = -10;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0; b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            b_in_valid = (idx < 4);
            b_in_data  = 32'(idx);
            #1;
            if (b_out_valid && b_out_ready) begin
                n_total++;
                if (b_out_data !== 32'(got) || b_out_last !== (got == 3))
                    $display("FAIL pad0 out[%0d] got d=%h l=%b want d=%h l=%b", got, b_out_data, b_out_last, 32'(got), got == 3);
                else n_pass++;
                got++; last_take = cyc;
            end
            if (b_frame_done) begin
                dones++;
                n_total++;
                if (got != 4 || cyc != last_take + 1)
                    $display("FAIL pad0 frame_done got outs=%0d cyc=%0d want outs=4 cyc=%0d", got, cyc, last_take + 1);
                else n_pass++;
            end
            if (b_in_valid && b_in_ready) idx++;
            if (dones > 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        #1;
        n_total++;
        if (got != 4 || dones != 1 || b_busy !== 1'b0)
            $display("FAIL pad0 summary got outs=%0d done=%0d busy=%b want 4 1 0", got, dones, b_busy);
        else n_pass++;
    endtask

`ifdef ZERO_UNPADDING_CHECK_EN
    task automatic test_pad_err();
        word_q_t w;
        for (int i = 0; i < AN; i++)
            w.push_back(is_interior(i) ? $urandom : ((i % 2) ? 32'h8000_0000 : 32'h0));
        w[0] = 32'h4190_0000;
        run_a(w, 100, 100, -1, -1, -1, "pad_err_set");
        n_total++;
        if (a_pad_err !== 1'b1) $display("FAIL pad_err_sticky got=%b want=1", a_pad_err);
        else n_pass++;
        w[0] = 32'h8000_0000;
        run_a(w, 80, 80, -1, -1, -1, "pad_err_clean");
    endtask
`endif

    initial begin
        test_reset();
        test_frame_basic();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_frame();
        test_random();
        test_back_to_back();
        test_pad0();
`ifdef ZERO_UNPADDING_CHECK_EN
        test_pad_err();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
